// File: rtl/mem_port_b_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_b_arbiter
//
// Purpose:
//   Shares port B of the dual-port program/data memory between two requesters.
//   Requester 0 (VGA scan fetch) has priority. Requester 1 (debug/loader or
//   DMA) is forced to win after MAX_WAIT consecutive lost arbitrations.
//   The grant is registered, and read data returns a fixed two cycles after
//   the sampling edge.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN
//                       requester N access request, write flag, address, data
//   gntN                one-cycle accept pulse (also the write acknowledge)
//   rvalidN             one-cycle read-data-valid pulse for requester N
//   rdata               shared read data, qualified by rvalid0/rvalid1
//   mem_we_b/mem_addr_b/mem_data_b
//                       memory port-B write enable, address and write data
//   mem_q_b             memory port-B read data (synchronous, 1-cycle latency)
//   starve_cnt          requester-1 consecutive-denial count (debug)
// ----------------------------------------------------------------------------
module mem_port_b_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_we_b,
    output logic [AW-1:0] mem_addr_b,
    output logic [DW-1:0] mem_data_b,
    input  logic [DW-1:0] mem_q_b,
    output logic [3:0]    starve_cnt
);

    logic          r_arm;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [3:0]    r_starve_cnt;

    logic          w_starved;
    logic          w_win0;
    logic          w_win1;

    // r_arm blocks arbitration on the first edge after reset release, so the
    // earliest grant follows the second posedge.
    assign w_starved = (r_starve_cnt >= 4'(MAX_WAIT));
    assign w_win0    = r_arm & req0 & ~(req1 & w_starved);
    assign w_win1    = r_arm & req1 & (~req0 | w_starved);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arm        <= 1'b0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_starve_cnt <= 4'd0;
        end else begin
            r_arm <= 1'b1;

            // Issue stage: registered grant and memory-port drive
            r_gnt0 <= w_win0;
            r_gnt1 <= w_win1;
            if (w_win0) begin
                r_we   <= we0;
                r_addr <= addr0;
                r_data <= wdata0;
            end else if (w_win1) begin
                r_we   <= we1;
                r_addr <= addr1;
                r_data <= wdata1;
            end else begin
                // Idle: no write; address/data hold their last values
                r_we <= 1'b0;
            end

            // Return stage: the memory samples the issued address on this edge,
            // so its data is on mem_q_b exactly when rvalid rises.
            r_rvalid0 <= r_gnt0 & ~r_we;
            r_rvalid1 <= r_gnt1 & ~r_we;

            // Starvation counter: counts only denials while req1 is held
            if (r_arm && req1 && !w_win1) begin
                if (r_starve_cnt != 4'hF) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_starve_cnt <= 4'd0;
            end
        end
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign rvalid0    = r_rvalid0;
    assign rvalid1    = r_rvalid1;
    assign rdata      = mem_q_b;
    assign mem_we_b   = r_we;
    assign mem_addr_b = r_addr;
    assign mem_data_b = r_data;
    assign starve_cnt = r_starve_cnt;

endmodule
